// File: rtl/maze_motion_engine_if.sv
// rtl/maze_motion_engine_if.sv - frame/tilt/wall inputs and position/score/status outputs of the motion engine
interface maze_motion_engine_if #(
    parameter int N = 49
);
    logic         frame_tick;
    logic         sec_tick;
    logic         posr;
    logic [4:0]   tilt_x;
    logic [4:0]   tilt_y;
    logic [N-1:0] hwall;
    logic [N-1:0] vwall;
    logic [10:0]  h_min;
    logic [10:0]  v_min;
    logic [15:0]  score;
    logic [7:0]   timer;
    logic [3:0]   lives;
    logic         game_over;
    logic         busy;
    logic         collided;
    logic         goal_hit;

    modport master (
        output frame_tick, sec_tick, posr, tilt_x, tilt_y, hwall, vwall,
        input  h_min, v_min, score, timer, lives, game_over, busy, collided, goal_hit
    );

    modport slave (
        input  frame_tick, sec_tick, posr, tilt_x, tilt_y, hwall, vwall,
        output h_min, v_min, score, timer, lives, game_over, busy, collided, goal_hit
    );
endinterface

// File: rtl/maze_motion_engine.sv
// rtl/maze_motion_engine.sv - per-frame tilt motion, serial wall collision scan, timer and score (lives via MAZE_LIVES_EN)
module maze_motion_engine #(
    parameter int GRID_W     = 7,
    parameter int GRID_H     = 7,
    parameter int CELL       = 60,
    parameter int ORIGIN_X   = 110,
    parameter int ORIGIN_Y   = 0,
    parameter int WALL_T     = 2,
    parameter int PWIDTH     = 16,
    parameter int VMAX       = 2,
    parameter int TIMER_INIT = 49,
    parameter int LIVES_INIT = 3
) (
    input  logic                clk_pix,
    input  logic                reset_n,
    maze_motion_engine_if.slave bus
);
    typedef logic signed [11:0] s12_t;

    localparam int N  = GRID_W * GRID_H;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    localparam s12_t BND_L   = s12_t'(ORIGIN_X + 1);
    localparam s12_t BND_R   = s12_t'(ORIGIN_X + GRID_W * CELL);
    localparam s12_t BND_T   = s12_t'(ORIGIN_Y + 2);
    localparam s12_t BND_B   = s12_t'(ORIGIN_Y + GRID_H * CELL);
    localparam s12_t GOAL_X1 = s12_t'(ORIGIN_X + (GRID_W - 1) * CELL + CELL / 4);
    localparam s12_t GOAL_X2 = s12_t'(ORIGIN_X + GRID_W * CELL - CELL / 4);
    localparam s12_t GOAL_Y1 = s12_t'(ORIGIN_Y + CELL / 4);
    localparam s12_t GOAL_Y2 = s12_t'(ORIGIN_Y + CELL - CELL / 4);
    localparam s12_t BASE_X0 = s12_t'(ORIGIN_X);
    localparam s12_t BASE_Y0 = s12_t'(ORIGIN_Y);
    localparam s12_t PW      = s12_t'(PWIDTH);
    localparam s12_t C_CELL  = s12_t'(CELL);
    localparam s12_t C_WALL  = s12_t'(WALL_T);
    localparam s12_t C_VMAX  = s12_t'(VMAX);

    localparam logic [10:0]   SPAWN_X = 11'(ORIGIN_X + 10);
    localparam logic [10:0]   SPAWN_Y = 11'(ORIGIN_Y + (GRID_H - 1) * CELL + 10);
    localparam logic [7:0]    TMR_RLD = 8'(TIMER_INIT);
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam logic [JW-1:0] J_LAST  = JW'(GRID_H - 1);

    function automatic s12_t vel(input logic [4:0] t);
        logic [4:0] mag;
        mag = t[4] ? (~t + 5'd1) : t;
        if (mag <= 5'd1)
            return '0;
        else if (mag == 5'd2)
            return t[4] ? -12'sd1 : 12'sd1;
        else
            return t[4] ? -C_VMAX : C_VMAX;
    endfunction

    // Inclusive overlap of the player box [bx..bx+PW] x [by..by+PW] with a rectangle
    function automatic logic ovl(input s12_t bx, input s12_t by, input s12_t x1,
                                 input s12_t x2, input s12_t y1, input s12_t y2);
        return (bx <= x2) && (bx + PW >= x1) && (by <= y2) && (by + PW >= y1);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
    state_t state, state_nx;

    logic start, scan_en, commit_en, busy_c, last_k;

    logic [N-1:0]  hw_s, vw_s;
    s12_t          dx, dy, base_x, base_y;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic          blk_x, blk_y;
    logic [10:0]   h, v;
    logic [15:0]   score_r;
    logic [7:0]    timer_r;
    logic          posr_pend, exp_pend, collided_r, goal_hit_r;
    logic [3:0]    lives_r;
    logic          game_over_r;

    s12_t        ph, pv, cx, cy;
    s12_t        hx1, hx2, hy1, hy2, vx1, vx2, vy1, vy2;
    logic [10:0] nh, nv;
    logic        hit_x, hit_y, stop_x, stop_y, goal_c;
    logic        frozen, score_clr;
    logic        do_posr, do_goal, do_exp, do_move, respawn, tick_exp;

    assign last_k = (k == K_LAST);

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.frame_tick) state_nx = S_SCAN;
            S_SCAN:   if (last_k) state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        start     = (state == S_IDLE) && bus.frame_tick;
        scan_en   = (state == S_SCAN);
        commit_en = (state == S_COMMIT);
        busy_c    = (state != S_IDLE);
    end

    // Segment rectangles derive from the running column/row bases, so no per-index multiply
    always_comb begin
        ph  = s12_t'({1'b0, h});
        pv  = s12_t'({1'b0, v});
        cx  = ph + dx;
        cy  = pv + dy;
        hx1 = base_x + 12'sd3;
        hx2 = base_x + C_CELL + 12'sd2;
        hy1 = base_y + C_CELL;
        hy2 = base_y + C_CELL + C_WALL - 12'sd1;
        vx1 = base_x + C_CELL + 12'sd1;
        vx2 = base_x + C_CELL + C_WALL;
        vy1 = base_y;
        vy2 = base_y + C_CELL - 12'sd1;
        hit_x = (hw_s[k] && ovl(cx, pv, hx1, hx2, hy1, hy2)) ||
                (vw_s[k] && ovl(cx, pv, vx1, vx2, vy1, vy2));
        hit_y = (hw_s[k] && ovl(ph, cy, hx1, hx2, hy1, hy2)) ||
                (vw_s[k] && ovl(ph, cy, vx1, vx2, vy1, vy2));
        stop_x = blk_x || (cx <= BND_L) || (cx + PW >= BND_R);
        stop_y = blk_y || (cy <= BND_T) || (cy + PW >= BND_B);
        nh     = stop_x ? h : cx[10:0];
        nv     = stop_y ? v : cy[10:0];
        goal_c = ovl(s12_t'({1'b0, nh}), s12_t'({1'b0, nv}), GOAL_X1, GOAL_X2, GOAL_Y1, GOAL_Y2);
    end

    always_comb begin
        do_posr  = commit_en && posr_pend;
        do_goal  = commit_en && !posr_pend && !frozen && goal_c;
        do_exp   = commit_en && !posr_pend && !frozen && !goal_c && exp_pend;
        do_move  = commit_en && !posr_pend && !frozen && !goal_c && !exp_pend;
        respawn  = do_posr || do_goal || do_exp;
        tick_exp = bus.sec_tick && !frozen && (timer_r == 8'd1);
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            hw_s   <= '0;
            vw_s   <= '0;
            dx     <= '0;
            dy     <= '0;
            k      <= '0;
            j      <= '0;
            base_x <= BASE_X0;
            base_y <= BASE_Y0;
            blk_x  <= 1'b0;
            blk_y  <= 1'b0;
        end else if (start) begin
            hw_s   <= bus.hwall;
            vw_s   <= bus.vwall;
            dx     <= vel(bus.tilt_x);
            dy     <= vel(bus.tilt_y);
            k      <= '0;
            j      <= '0;
            base_x <= BASE_X0;
            base_y <= BASE_Y0;
            blk_x  <= 1'b0;
            blk_y  <= 1'b0;
        end else if (scan_en) begin
            blk_x <= blk_x || hit_x;
            blk_y <= blk_y || hit_y;
            if (!last_k) begin
                k <= k + 1'b1;
                if (j == J_LAST) begin
                    j      <= '0;
                    base_y <= BASE_Y0;
                    base_x <= base_x + C_CELL;
                end else begin
                    j      <= j + 1'b1;
                    base_y <= base_y + C_CELL;
                end
            end
        end
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            h          <= SPAWN_X;
            v          <= SPAWN_Y;
            score_r    <= '0;
            collided_r <= 1'b0;
            goal_hit_r <= 1'b0;
        end else begin
            collided_r <= 1'b0;
            goal_hit_r <= 1'b0;
            if (respawn) begin
                h <= SPAWN_X;
                v <= SPAWN_Y;
            end else if (do_move) begin
                h <= nh;
                v <= nv;
            end
            if (do_goal) begin
                goal_hit_r <= 1'b1;
                if (score_r != 16'hFFFF)
                    score_r <= score_r + 16'd1;
            end else if (score_clr) begin
                score_r <= '0;
            end
            if (do_move)
                collided_r <= (stop_x && (dx != 12'sd0)) || (stop_y && (dy != 12'sd0));
        end
    end

    // A fresh request arriving during COMMIT survives the clear
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            timer_r   <= TMR_RLD;
            posr_pend <= 1'b0;
            exp_pend  <= 1'b0;
        end else begin
            posr_pend <= bus.posr || (posr_pend && !commit_en);
            exp_pend  <= tick_exp || (exp_pend && !commit_en);
            if (respawn || tick_exp)
                timer_r <= TMR_RLD;
            else if (bus.sec_tick && !frozen)
                timer_r <= timer_r - 8'd1;
        end
    end

`ifdef MAZE_LIVES_EN
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            lives_r     <= 4'(LIVES_INIT);
            game_over_r <= 1'b0;
        end else if (do_posr) begin
            lives_r     <= 4'(LIVES_INIT);
            game_over_r <= 1'b0;
        end else if (do_exp) begin
            if (lives_r != 4'd0)
                lives_r <= lives_r - 4'd1;
            if (lives_r <= 4'd1)
                game_over_r <= 1'b1;
        end
    end
    assign frozen    = game_over_r;
    assign score_clr = do_posr;
`else
    assign lives_r     = 4'd0;
    assign game_over_r = 1'b0;
    assign frozen      = 1'b0;
    assign score_clr   = 1'b0;
`endif

    assign bus.h_min     = h;
    assign bus.v_min     = v;
    assign bus.score     = score_r;
    assign bus.timer     = timer_r;
    assign bus.lives     = lives_r;
    assign bus.game_over = game_over_r;
    assign bus.busy      = busy_c;
    assign bus.collided  = collided_r;
    assign bus.goal_hit  = goal_hit_r;
endmodule

// File: tb/tb_maze_motion_engine.sv
// tb/tb_maze_motion_engine.sv - scoreboard bench for maze_motion_engine (default 7x7 and a 1x1 goal instance)
module tb_maze_motion_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maze_motion_engine_if #(.N(49)) ifc0 ();
    maze_motion_engine_if #(.N(1))  ifc1 ();

    maze_motion_engine dut0 (.clk_pix(clk), .reset_n(rst_n), .bus(ifc0));
    maze_motion_engine #(.GRID_W(1), .GRID_H(1)) dut1 (.clk_pix(clk), .reset_n(rst_n), .bus(ifc1));

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        col;
        logic        goal;
        logic [15:0] score;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t snap0();
        return {ifc0.h_min, ifc0.v_min, ifc0.collided, ifc0.goal_hit, ifc0.score};
    endfunction

    function automatic obs_t snap1();
        return {ifc1.h_min, ifc1.v_min, ifc1.collided, ifc1.goal_hit, ifc1.score};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fire0();
        @(negedge clk);
        ifc0.frame_tick = 1'b1;
        @(negedge clk);
        ifc0.frame_tick = 1'b0;
    endtask

    task automatic wait_idle0(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!ifc0.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic tick_sec(input int cnt);
        repeat (cnt) begin
            @(negedge clk);
            ifc0.sec_tick = 1'b1;
            @(negedge clk);
            ifc0.sec_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        obs_t o;
        o = snap0();
        n_cmp++;
        if (o !== obs_t'({11'd120, 11'd370, 1'b0, 1'b0, 16'd0})) begin
            n_bad++;
            $display("FAIL reset_pos: got h=%0d v=%0d col=%b goal=%b score=%0d, want 120 370 0 0 0",
                     o.h, o.v, o.col, o.goal, o.score);
        end
        n_cmp++;
        if (ifc0.timer !== 8'd49 || ifc0.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_timer_busy: got timer=%0d busy=%b, want 49 0", ifc0.timer, ifc0.busy);
        end
`ifdef MAZE_LIVES_EN
        n_cmp++;
        if (ifc0.lives !== 4'd3 || ifc0.game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lives: got lives=%0d go=%b, want 3 0", ifc0.lives, ifc0.game_over);
        end
`else
        n_cmp++;
        if (ifc0.lives !== 4'd0 || ifc0.game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lives: got lives=%0d go=%b, want 0 0", ifc0.lives, ifc0.game_over);
        end
`endif
        n_cmp++;
        if (ifc1.h_min !== 11'd120 || ifc1.v_min !== 11'd10) begin
            n_bad++;
            $display("FAIL reset_pos_1x1: got h=%0d v=%0d, want 120 10", ifc1.h_min, ifc1.v_min);
        end
    endtask

    task automatic test_goal();
        obs_t e, o;
        bit   ok;
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{h: 11'd120, v: 11'd10, col: 1'b0, goal: 1'b1, score: 16'(r + 1)});
            @(negedge clk);
            ifc1.frame_tick = 1'b1;
            @(negedge clk);
            ifc1.frame_tick = 1'b0;
            ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                if (!ifc1.busy) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            e = sb.pop_front();
            o = snap1();
            n_cmp++;
            if (!ok || o !== e) begin
                n_bad++;
                $display("FAIL goal frame %0d: got h=%0d v=%0d col=%b goal=%b score=%0d idle=%b, want h=%0d v=%0d col=%b goal=%b score=%0d",
                         r, o.h, o.v, o.col, o.goal, o.score, ok, e.h, e.v, e.col, e.goal, e.score);
            end
        end
    endtask

    task automatic test_left_wall();
        obs_t e, o;
        bit   ok;
        ifc0.tilt_x = 5'h1D;
        for (int f = 0; f < 5; f++) begin
            sb.push_back('{h: (f < 4) ? 11'(118 - 2 * f) : 11'd112, v: 11'd370,
                           col: (f == 4), goal: 1'b0, score: 16'd0});
            fire0();
            wait_idle0(ok);
            e = sb.pop_front();
            o = snap0();
            n_cmp++;
            if (!ok || o !== e) begin
                n_bad++;
                $display("FAIL left_wall frame %0d: got h=%0d v=%0d col=%b goal=%b idle=%b, want h=%0d v=%0d col=%b goal=%b",
                         f, o.h, o.v, o.col, o.goal, ok, e.h, e.v, e.col, e.goal);
            end
        end
    endtask

    task automatic test_vwall();
        obs_t e, o;
        bit   ok;
        int   eh;
        apply_reset();
        ifc0.vwall    = '0;
        ifc0.vwall[6] = 1'b1;
        ifc0.tilt_x   = 5'd3;
        for (int f = 0; f < 18; f++) begin
            eh = (122 + 2 * f > 154) ? 154 : 122 + 2 * f;
            sb.push_back('{h: 11'(eh), v: 11'd370, col: (f == 17), goal: 1'b0, score: 16'd0});
            fire0();
            wait_idle0(ok);
            e = sb.pop_front();
            o = snap0();
            n_cmp++;
            if (!ok || o !== e) begin
                n_bad++;
                $display("FAIL vwall frame %0d: got h=%0d v=%0d col=%b idle=%b, want h=%0d v=%0d col=%b",
                         f, o.h, o.v, o.col, ok, e.h, e.v, e.col);
            end
        end
    endtask

    task automatic test_snapshot();
        obs_t e, o;
        bit   ok;
        ifc0.vwall = '0;
        sb.push_back('{h: 11'd156, v: 11'd370, col: 1'b0, goal: 1'b0, score: 16'd0});
        fire0();
        ifc0.vwall[6] = 1'b1;
        wait_idle0(ok);
        ifc0.vwall = '0;
        e = sb.pop_front();
        o = snap0();
        n_cmp++;
        if (!ok || o !== e) begin
            n_bad++;
            $display("FAIL snapshot: got h=%0d col=%b idle=%b, want h=%0d col=%b", o.h, o.col, ok, e.h, e.col);
        end
    endtask

    task automatic test_timer();
        obs_t e, o;
        bit   ok;
        ifc0.tilt_x = 5'd0;
        tick_sec(48);
        n_cmp++;
        if (ifc0.timer !== 8'd1) begin
            n_bad++;
            $display("FAIL timer_count: got %0d, want 1", ifc0.timer);
        end
        sb.push_back('{h: 11'd120, v: 11'd370, col: 1'b0, goal: 1'b0, score: 16'd0});
        fire0();
        tick_sec(1);
        wait_idle0(ok);
        e = sb.pop_front();
        o = snap0();
        n_cmp++;
        if (!ok || o !== e || ifc0.timer !== 8'd49) begin
            n_bad++;
            $display("FAIL timer_expiry: got h=%0d v=%0d timer=%0d idle=%b, want h=%0d v=%0d timer=49",
                     o.h, o.v, ifc0.timer, ok, e.h, e.v);
        end
`ifdef MAZE_LIVES_EN
        n_cmp++;
        if (ifc0.lives !== 4'd2 || ifc0.game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL lives_first: got lives=%0d go=%b, want 2 0", ifc0.lives, ifc0.game_over);
        end
        for (int x = 0; x < 2; x++) begin
            tick_sec(49);
            fire0();
            wait_idle0(ok);
        end
        n_cmp++;
        if (ifc0.lives !== 4'd0 || ifc0.game_over !== 1'b1) begin
            n_bad++;
            $display("FAIL game_over: got lives=%0d go=%b, want 0 1", ifc0.lives, ifc0.game_over);
        end
        ifc0.tilt_x = 5'd3;
        fire0();
        wait_idle0(ok);
        n_cmp++;
        if (!ok || ifc0.h_min !== 11'd120) begin
            n_bad++;
            $display("FAIL frozen_move: got h=%0d idle=%b, want 120", ifc0.h_min, ok);
        end
        @(negedge clk);
        ifc0.posr = 1'b1;
        @(negedge clk);
        ifc0.posr = 1'b0;
        fire0();
        wait_idle0(ok);
        n_cmp++;
        if (!ok || ifc0.lives !== 4'd3 || ifc0.game_over !== 1'b0 || ifc0.h_min !== 11'd120) begin
            n_bad++;
            $display("FAIL posr_restart: got lives=%0d go=%b h=%0d, want 3 0 120",
                     ifc0.lives, ifc0.game_over, ifc0.h_min);
        end
        ifc0.tilt_x = 5'd0;
`else
        n_cmp++;
        if (ifc0.lives !== 4'd0 || ifc0.game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL no_lives: got lives=%0d go=%b, want 0 0", ifc0.lives, ifc0.game_over);
        end
`endif
    endtask

    task automatic test_posr();
        obs_t e, o;
        bit   ok;
        ifc0.tilt_x = 5'd3;
        for (int f = 0; f < 2; f++) begin
            sb.push_back('{h: (f == 0) ? 11'd122 : 11'd120, v: 11'd370, col: 1'b0, goal: 1'b0, score: 16'd0});
            if (f == 1) begin
                @(negedge clk);
                ifc0.posr = 1'b1;
                @(negedge clk);
                ifc0.posr = 1'b0;
            end
            fire0();
            wait_idle0(ok);
            e = sb.pop_front();
            o = snap0();
            n_cmp++;
            if (!ok || o !== e) begin
                n_bad++;
                $display("FAIL posr frame %0d: got h=%0d v=%0d col=%b idle=%b, want h=%0d v=%0d col=%b",
                         f, o.h, o.v, o.col, ok, e.h, e.v, e.col);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        int   cnt;
        sb.push_back('{h: 11'd122, v: 11'd370, col: 1'b0, goal: 1'b0, score: 16'd0});
        cnt = 0;
        @(negedge clk);
        ifc0.frame_tick = 1'b1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            ifc0.frame_tick = (c == 5);
            if (ifc0.busy)
                cnt++;
            else if (c > 1)
                break;
        end
        ifc0.frame_tick = 1'b0;
        e = sb.pop_front();
        o = snap0();
        n_cmp++;
        if (cnt != 50 || o !== e) begin
            n_bad++;
            $display("FAIL back_to_back: got busy_cycles=%0d h=%0d, want 50 %0d", cnt, o.h, e.h);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (ifc0.busy !== 1'b0 || ifc0.h_min !== 11'd122) begin
            n_bad++;
            $display("FAIL back_to_back_drop: got busy=%b h=%0d, want 0 122", ifc0.busy, ifc0.h_min);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        ifc0.tilt_x = 5'd3;
        fire0();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = snap0();
        n_cmp++;
        if (ifc0.busy !== 1'b0 || o !== obs_t'({11'd120, 11'd370, 1'b0, 1'b0, 16'd0}) || ifc0.timer !== 8'd49) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b h=%0d v=%0d col=%b score=%0d timer=%0d, want 0 120 370 0 0 49",
                     ifc0.busy, o.h, o.v, o.col, o.score, ifc0.timer);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++;
        if (ifc0.busy !== 1'b0 || ifc0.h_min !== 11'd120) begin
            n_bad++;
            $display("FAIL reset_mid_no_commit: got busy=%b h=%0d, want 0 120", ifc0.busy, ifc0.h_min);
        end
    endtask

    initial begin
        ifc0.frame_tick = 1'b0; ifc0.sec_tick = 1'b0; ifc0.posr = 1'b0;
        ifc0.tilt_x = '0; ifc0.tilt_y = '0; ifc0.hwall = '0; ifc0.vwall = '0;
        ifc1.frame_tick = 1'b0; ifc1.sec_tick = 1'b0; ifc1.posr = 1'b0;
        ifc1.tilt_x = '0; ifc1.tilt_y = '0; ifc1.hwall = '0; ifc1.vwall = '0;
        apply_reset();
        test_reset();
        test_goal();
        test_left_wall();
        test_vwall();
        test_snapshot();
        test_timer();
        test_posr();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/maze_motion_engine.md
# maze_motion_engine

Per-frame player motion and collision engine for the tilt-controlled maze game, parametrised in grid size, cell pitch and speed. Once per frame it snapshots the horizontal and vertical wall bitmaps and serially scans all wall segments, one grid index per cycle. It blocks each movement axis independently and commits the new player position. It also keeps the countdown timer and score, handles respawn, and feeds the VGA renderer and seven-segment driver in the `clk_pix` domain.

## Interface
- `GRID_W`, 7, grid columns
- `GRID_H`, 7, grid rows; N = GRID_W*GRID_H
- `CELL`, 60, cell pitch in pixels
- `ORIGIN_X`, 110, arena left x
- `ORIGIN_Y`, 0, arena top y
- `WALL_T`, 2, wall thickness in pixels
- `PWIDTH`, 16, player box extent; box spans [min, min+PWIDTH]
- `VMAX`, 2, speed for |tilt| >= 3
- `TIMER_INIT`, 49, countdown reload value
- `LIVES_INIT`, 3, lives reload value (LIVES_EN only)

- `clk_pix`  in  1  pixel clock, sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per frame, asserted in vertical blank
- `sec_tick`  in  1  one-cycle pulse per second
- `posr`  in  1  respawn request pulse
- `tilt_x`, `tilt_y`  in  5 each  signed two's complement tilt
- `hwall`, `vwall`  in  N each  wall present = 1; index k = GRID_H*i + j
- `h_min`, `v_min`  out  11 each  player top-left position
- `score`  out  16  goals reached, saturates at 16'hFFFF
- `timer`  out  8  seconds remaining
- `lives`  out  4  lives remaining
- `game_over`  out  1  level signal
- `busy`  out  1  high while a frame is being processed
- `collided`  out  1  one-cycle pulse
- `goal_hit`  out  1  one-cycle pulse

## Operation
- **Velocity per axis:** |t| <= 1 gives 0; |t| == 2 gives ±1; |t| >= 3 gives ±VMAX; the sign follows t. dx comes from `tilt_x`, dy from `tilt_y`.
- **Horizontal segment k** (column i, row j):
  - x1 = ORIGIN_X + i*CELL + 3, x2 = x1 + CELL - 1
  - y1 = ORIGIN_Y + (j+1)*CELL, y2 = y1 + WALL_T - 1
- **Vertical segment k:**
  - x1 = ORIGIN_X + 1 + (i+1)*CELL, x2 = x1 + WALL_T - 1
  - y1 = ORIGIN_Y + j*CELL, y2 = y1 + CELL - 1
- **Segment addresses:** computed incrementally from i/j counters; no multipliers per index.
- **Arena bounds:**
  - L = ORIGIN_X + 1, R = ORIGIN_X + GRID_W*CELL
  - T = ORIGIN_Y + 2, B = ORIGIN_Y + GRID_H*CELL
- **Candidate arithmetic:** 12-bit signed.
- **X blocked** if any of:
  - h_min + dx <= L
  - h_min + dx + PWIDTH >= R
  - any present segment overlaps the box [h_min+dx .. +PWIDTH] × [v_min .. +PWIDTH], using inclusive overlap
- **Y blocked:** same rule with dy applied on the y axis, using bounds T and B.
- **Wall contact:** blocks only the affected axis; it never kills the player.
- **FSM states:**
  - IDLE: `frame_tick` latches `hwall`/`vwall` into shadow registers and moves to SCAN (k = 0).
  - SCAN: tests hwall[k] and vwall[k] against both axis candidates in one cycle. k increments; after k = N-1 the FSM moves to COMMIT.
  - COMMIT: updates state, then returns to IDLE.
- **COMMIT priority:** posr-pending > goal > timer-expiry > move.
  - Respawn sets h_min = ORIGIN_X + 10 and v_min = ORIGIN_Y + (GRID_H-1)*CELL + 10, and reloads the timer.
  - Goal: the committed box overlaps [ORIGIN_X+(GRID_W-1)*CELL+CELL/4, ORIGIN_X+GRID_W*CELL-CELL/4] × [ORIGIN_Y+CELL/4, ORIGIN_Y+CELL-CELL/4]. Effect: `goal_hit` pulse, score+1, respawn.
  - Move: each unblocked axis adds its delta; `collided` pulses if either axis was blocked with a nonzero delta.
- **Timer:** each `sec_tick` decrements it. A tick at timer == 1 reloads TIMER_INIT and sets expire-pending, which is consumed at the next COMMIT.
- **`posr`:** sets posr-pending at any time; the flag clears at COMMIT.

## Timing
- **Reset values:**
  - h_min = ORIGIN_X + 10, v_min = ORIGIN_Y + (GRID_H-1)*CELL + 10
  - score 0, timer TIMER_INIT, lives LIVES_INIT (0 without LIVES_EN)
  - game_over 0, busy 0, pulses 0; FSM in IDLE; pending flags cleared
- **Frame latency:** `frame_tick` at edge 0 → busy = 1 from edge 1, SCAN occupies edges 1..N, COMMIT at edge N+1. Outputs and pulses are valid after edge N+1; busy = 0 after edge N+1.
- **Ignored ticks:** a `frame_tick` while busy is dropped.
- **Wall snapshot:** `hwall`/`vwall` changes during SCAN do not affect the current frame.
- **`sec_tick` during SCAN:** the timer still updates; expiry is applied at this frame's COMMIT if it is pending by then.
- **Reset mid-operation:** `reset_n` low mid-SCAN returns all state to reset values immediately; no COMMIT occurs.

## Configuration
- Macro: `MAZE_LIVES_EN`.
- **Defined:**
  - Timer expiry decrements `lives`.
  - When lives reach 0, `game_over` = 1; motion, timer and goal detection freeze, but frames are still scanned.
  - `posr` clears `game_over`, reloads lives to LIVES_INIT, clears score and respawns.
- **Undefined:** `lives` = 0 and `game_over` = 0 constantly; expiry only respawns.

## Test plan
- Defaults, tilt_x = -3, all walls 0: h_min 120→118→116→114→112. The next frame is blocked (candidate 110 <= 111): h_min stays 112 and `collided` pulses.
- vwall[6] = 1 only, tilt_x = +3: h_min advances by 2 to 154, then stays at 154 with `collided` pulsing.
- GRID_W = GRID_H = 1: the first frame gives `goal_hit`, score = 1, position back to (120, 10).
- TIMER_INIT = 3, three `sec_tick` pulses, then a frame: respawn, timer = 3. With MAZE_LIVES_EN, lives 3→2; after two more expiries, game_over = 1 and tilt is ignored.
- `frame_tick` pulses on edge 0 and again on edge 5 (N = 49): only one COMMIT occurs, at edge 50.
- `reset_n` low at SCAN k = 20 while tilt_x = +3: all outputs read reset values, busy = 0, and no position change is seen.
